// File: rtl/alu_seq.sv
// alu_seq: runs a W-bit operation through one external 4-bit ALU slice, one nibble per cycle.
// Latency: rsp_valid_o rises NIBBLES clock edges after the command handshake edge.
// Backpressure: one command in flight. cmd_ready_o is high only in IDLE. The result is held in DONE until rsp_ready_i.
//
// Ports:
//   clk_i, rst_i                 clock and synchronous active-high reset
//   cmd_valid_i / cmd_ready_o    command handshake; mode, select, a, b and cin are latched on accept
//   rsp_valid_o / rsp_ready_i    response handshake; f, cout and eq are the assembled result
//   alu_*_o                      drive the external slice while in RUN; all are zero otherwise
//   alu_f_i, alu_cout_i,         combinational slice outputs for the nibble currently presented
//   alu_cmp_i
module alu_seq #(
    parameter int NIBBLES = 4,
    localparam int W  = 4 * NIBBLES,
    localparam int IW = $clog2(NIBBLES)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic         cmd_mode_i,
    input  logic [3:0]   cmd_select_i,
    input  logic [W-1:0] cmd_a_i,
    input  logic [W-1:0] cmd_b_i,
    input  logic         cmd_cin_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [W-1:0] rsp_f_o,
    output logic         rsp_cout_o,
    output logic         rsp_eq_o,
    output logic         alu_mode_o,
    output logic [3:0]   alu_select_o,
    output logic [3:0]   alu_a_o,
    output logic [3:0]   alu_b_o,
    output logic         alu_cin_o,
    input  logic [3:0]   alu_f_i,
    input  logic         alu_cout_i,
    input  logic         alu_cmp_i
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           mode_q, mode_d;
    logic [3:0]     sel_q, sel_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           cin_q, cin_d;
    logic [W-1:0]   res_q, res_d;
    logic           cout_q, cout_d;
    logic           eq_acc_q, eq_acc_d;
    // The visible eq flag is separate from the running accumulator.
    // This keeps the previous result's eq stable through IDLE and RUN.
    logic           eq_q, eq_d;
    logic           last_nib;

    assign last_nib    = (idx_q == IW'(NIBBLES - 1));
    assign cmd_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == DONE);
    assign rsp_f_o     = res_q;
    assign rsp_cout_o  = cout_q;
    assign rsp_eq_o    = eq_q;

    // Slice drive: zero outside RUN.
    // The carry into nibble 0 is the command carry. Later nibbles use the carry registered from the previous nibble.
    always_comb begin
        alu_mode_o   = 1'b0;
        alu_select_o = 4'd0;
        alu_a_o      = 4'd0;
        alu_b_o      = 4'd0;
        alu_cin_o    = 1'b0;
        if (state_q == RUN) begin
            alu_mode_o   = mode_q;
            alu_select_o = sel_q;
            alu_a_o      = a_q[{idx_q, 2'b00} +: 4];
            alu_b_o      = b_q[{idx_q, 2'b00} +: 4];
            alu_cin_o    = (idx_q == '0) ? cin_q : cout_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mode_d   = mode_q;
        sel_d    = sel_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        res_d    = res_q;
        cout_d   = cout_q;
        eq_acc_d = eq_acc_q;
        eq_d     = eq_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    mode_d   = cmd_mode_i;
                    sel_d    = cmd_select_i;
                    a_d      = cmd_a_i;
                    b_d      = cmd_b_i;
                    cin_d    = cmd_cin_i;
                    idx_d    = '0;
                    eq_acc_d = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                res_d[{idx_q, 2'b00} +: 4] = alu_f_i;
                cout_d   = alu_cout_i;
                eq_acc_d = eq_acc_q & alu_cmp_i;
                if (last_nib) begin
                    eq_d    = eq_acc_q & alu_cmp_i;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            mode_q   <= 1'b0;
            sel_q    <= 4'd0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            res_q    <= '0;
            cout_q   <= 1'b0;
            eq_acc_q <= 1'b1;
            eq_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mode_q   <= mode_d;
            sel_q    <= sel_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            res_q    <= res_d;
            cout_q   <= cout_d;
            eq_acc_q <= eq_acc_d;
            eq_q     <= eq_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq with NIBBLES = 4, using a behavioural 4-bit slice.
// Latency: each command is checked for a response exactly NIBBLES edges after acceptance.
// Backpressure: covers a held response, rsp_ready raised early, and back-to-back commands.
module tb_alu_seq;
    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct packed {
        logic [W-1:0] f;
        logic         cout;
        logic         eq;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready, cmd_mode, cmd_cin;
    logic [3:0]   cmd_select;
    logic [W-1:0] cmd_a, cmd_b;
    logic         rsp_valid, rsp_ready, rsp_cout, rsp_eq;
    logic [W-1:0] rsp_f;
    logic         alu_mode, alu_cin, alu_cout, alu_cmp;
    logic [3:0]   alu_select, alu_a, alu_b, alu_f;
    logic [4:0]   slice_sum;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.NIBBLES(N)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_mode_i(cmd_mode), .cmd_select_i(cmd_select),
        .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_cin_i(cmd_cin),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_f_o(rsp_f), .rsp_cout_o(rsp_cout), .rsp_eq_o(rsp_eq),
        .alu_mode_o(alu_mode), .alu_select_o(alu_select),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_cin_o(alu_cin),
        .alu_f_i(alu_f), .alu_cout_i(alu_cout), .alu_cmp_i(alu_cmp)
    );

    // Behavioural slice model.
    // Arithmetic mode with select 1001 adds the nibbles with carry.
    // Logic mode with select 1001 returns XNOR, so compare reports A == B.
    always_comb begin
        slice_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
        alu_f     = 4'd0;
        alu_cout  = 1'b0;
        if (alu_select == 4'b1001) begin
            if (alu_mode == 1'b0) begin
                alu_f    = slice_sum[3:0];
                alu_cout = slice_sum[4];
            end else begin
                alu_f = ~(alu_a ^ alu_b);
            end
        end
        alu_cmp = (alu_f == 4'hF);
    end

    function automatic exp_t model(input logic mode, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cin);
        exp_t       e;
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        if (mode == 1'b0) begin
            e.f    = s[W-1:0];
            e.cout = s[W];
        end else begin
            e.f    = ~(a ^ b);
            e.cout = 1'b0;
        end
        e.eq = (e.f == {W{1'b1}});
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive a command at a negedge, then return at the negedge after the accepting edge.
    task automatic send(input logic mode, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input bit push, input bit hold);
        chk("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        cmd_valid  = 1'b1;
        cmd_mode   = mode;
        cmd_select = 4'b1001;
        cmd_a      = a;
        cmd_b      = b;
        cmd_cin    = cin;
        if (push) sb.push_back(model(mode, a, b, cin));
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Walk the RUN phase, recording carries, until DONE appears or the budget runs out.
    task automatic run_phase(input logic [W-1:0] a, output logic [3:0] cins);
        int cnt = 0;
        cins = 4'd0;
        while (rsp_valid !== 1'b1 && cnt < 20) begin
            if (cnt < N) begin
                chk("alu_a_nibble", {28'd0, alu_a}, {28'd0, a[4*cnt +: 4]});
                cins[cnt] = alu_cin;
                chk("ready_low_in_run", {31'd0, cmd_ready}, 32'd0);
            end
            @(negedge clk);
            cnt++;
        end
        chk("latency_edges", cnt, N);
    endtask

    task automatic take_rsp();
        exp_t e;
        rsp_ready = 1'b1;
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk("rsp_f", {16'd0, rsp_f}, {16'd0, e.f});
            chk("rsp_cout", {31'd0, rsp_cout}, {31'd0, e.cout});
            chk("rsp_eq", {31'd0, rsp_eq}, {31'd0, e.eq});
        end
        @(negedge clk);
        chk("idle_ready_after_hs", {31'd0, cmd_ready}, 32'd1);
        chk("valid_low_after_hs", {31'd0, rsp_valid}, 32'd0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [3:0] cins;
        int         seen;
        rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_select = 4'd0;
        cmd_a = '0; cmd_b = '0; cmd_cin = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_f", {16'd0, rsp_f}, 32'd0);
        chk("rst_cout", {31'd0, rsp_cout}, 32'd0);
        chk("rst_eq", {31'd0, rsp_eq}, 32'd1);
        chk("rst_alu", {22'd0, alu_mode, alu_select, alu_a, alu_cin}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Plain add with an internal carry ripple.
        send(1'b0, 16'h0FFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        run_phase(16'h0FFF, cins);
        take_rsp();

        // Full overflow: the carry must chain into every upper nibble.
        send(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        run_phase(16'hFFFF, cins);
        chk("ovf_cin_nibbles", {28'd0, cins}, 32'hE);
        take_rsp();

        // Carry-in only, producing all ones, so eq is set.
        send(1'b0, 16'hFFFE, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_phase(16'hFFFE, cins);
        chk("cin0_used", {31'd0, cins[0]}, 32'd1);
        take_rsp();

        // Logic-mode equality compare, first equal operands, then unequal ones.
        send(1'b1, 16'hA5C3, 16'hA5C3, 1'b0, 1'b1, 1'b0);
        run_phase(16'hA5C3, cins);
        take_rsp();
        send(1'b1, 16'hA5C3, 16'hA5C2, 1'b0, 1'b1, 1'b0);
        run_phase(16'hA5C3, cins);
        take_rsp();

        // Hold DONE for 5 cycles while a competing command is presented.
        send(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b1, 1'b0);
        run_phase(16'h1234, cins);
        cmd_valid = 1'b1; cmd_a = 16'h1111; cmd_b = 16'h2222;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
            chk("bp_f_held", {16'd0, rsp_f}, 32'h5555);
            chk("bp_ready_low", {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        take_rsp();

        // Reset while nibble 2 is on the slice discards the operation.
        send(1'b0, 16'h7777, 16'h1111, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_ready_low", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("midrst_f", {16'd0, rsp_f}, 32'd0);
        chk("midrst_alu_a", {28'd0, alu_a}, 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        chk("midrst_no_rsp", seen, 0);

        // Back-to-back: valid held across DONE, with rsp_ready raised before DONE.
        rsp_ready = 1'b1;
        send(1'b0, 16'h00FF, 16'h0F01, 1'b0, 1'b1, 1'b1);
        cmd_a = 16'h8000; cmd_b = 16'h8000;
        run_phase(16'h00FF, cins);
        take_rsp();
        sb.push_back(model(1'b0, 16'h8000, 16'h8000, 1'b0));
        @(negedge clk);
        cmd_valid = 1'b0;
        run_phase(16'h8000, cins);
        take_rsp();
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit nibbles per operation; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset; synchronous to clk_i, active-high.
REQ-004 cmd_valid_i  input  1  command request.
REQ-005 cmd_ready_o  output  1  block can accept a command.
REQ-006 cmd_mode_i  input  1  mode control for the 4-bit ALU slice (1 = logic, 0 = arithmetic).
REQ-007 cmd_select_i  input  4  function select for the slice.
REQ-008 cmd_a_i  input  W  operand A.
REQ-009 cmd_b_i  input  W  operand B.
REQ-010 cmd_cin_i  input  1  carry into nibble 0.
REQ-011 rsp_valid_o  output  1  result available.
REQ-012 rsp_ready_i  input  1  consumer accepts result.
REQ-013 rsp_f_o  output  W  assembled result.
REQ-014 rsp_cout_o  output  1  carry out of the most-significant nibble.
REQ-015 rsp_eq_o  output  1  AND of slice compare output over all nibbles.
REQ-016 alu_mode_o, alu_select_o  output  1, 4  drive the slice mode/select.
REQ-017 alu_a_o, alu_b_o  output  4, 4  drive the slice operand nibbles.
REQ-018 alu_cin_o  output  1  drives the slice carry input.
REQ-019 alu_f_i, alu_cout_i, alu_cmp_i  input  4, 1, 1  slice function output, carry output, compare output (combinational from alu_* outputs).

Function
REQ-020 FSM states IDLE, RUN, DONE; exactly one active.
REQ-021 cmd_ready_o SHALL be 1 only in IDLE; rsp_valid_o SHALL be 1 only in DONE.
REQ-022 IDLE: cmd_valid_i & cmd_ready_o -> latch mode, select, A, B, cin; nibble index idx = 0; eq accumulator = 1; go RUN.
REQ-023 RUN, every cycle: alu_a_o = A[4*idx+3:4*idx], alu_b_o = B[4*idx+3:4*idx], alu_mode_o/alu_select_o = latched values.
REQ-024 RUN: alu_cin_o = latched cmd_cin for idx 0; for idx > 0, alu_cin_o = alu_cout_i registered at end of the previous RUN cycle.
REQ-025 RUN, each clock edge: store alu_f_i into result nibble idx, register alu_cout_i, eq_acc &= alu_cmp_i, idx increments.
REQ-026 RUN with idx = NIBBLES-1 at clock edge: go DONE; total latency from command handshake edge to rsp_valid_o = NIBBLES+1 cycles... i.e. rsp_valid_o rises on the edge ending the last RUN cycle (NIBBLES edges after acceptance).
REQ-027 DONE: rsp_f_o, rsp_cout_o (last registered cout), rsp_eq_o held stable until rsp_valid_o & rsp_ready_i; then IDLE next cycle.
REQ-028 Outside RUN, alu_a_o, alu_b_o, alu_select_o, alu_mode_o, alu_cin_o SHALL be 0.
REQ-029 Command inputs ignored when cmd_ready_o = 0; no queueing; cmd_valid_i held across DONE is accepted only after return to IDLE.
REQ-030 rsp_ready_i high before DONE has no effect; rsp_f_o/rsp_cout_o/rsp_eq_o retain last result values in IDLE and RUN until overwritten nibble-by-nibble.
REQ-031 idx counter width = ceil(log2(NIBBLES)); no wrap beyond NIBBLES-1.

Reset
REQ-032 rst_i high at a clock edge -> IDLE, idx = 0, result/cout = 0, eq_acc = 1, all latched command fields 0, in any state including mid-RUN (operation discarded, no response).
REQ-033 Reset values: cmd_ready_o = 1 (first cycle after reset release... i.e. while in IDLE), rsp_valid_o = 0, rsp_f_o = 0, rsp_cout_o = 0, rsp_eq_o = 1, all alu_* outputs 0.

Verification (NIBBLES = 4, behavioral slice model: mode 0, select 1001 -> F = A+B+cin nibble, cout = carry; compare = (F == 4'hF))
REQ-034 Add: A = 16'h0FFF, B = 16'h0001, cin 0 -> rsp_f_o = 16'h1000, rsp_cout_o = 0, rsp_valid_o 4 edges after acceptance.
REQ-035 Overflow: A = 16'hFFFF, B = 16'h0001, cin 0 -> rsp_f_o = 16'h0000, rsp_cout_o = 1; alu_cin_o = 1 on nibbles 1..3.
REQ-036 Backpressure: rsp_ready_i = 0 for 5 cycles in DONE -> rsp_valid_o and data stable, cmd_ready_o = 0 throughout; IDLE one cycle after rsp_ready_i = 1.
REQ-037 Reset mid-RUN: rst_i asserted at idx = 2 -> next cycle IDLE, cmd_ready_o = 1, rsp_valid_o never asserted for that command, rsp_f_o = 0.
REQ-038 Back-to-back: cmd_valid_i held high across two commands -> second accepted exactly one cycle after first response handshake; both results correct.
